// File: rtl/button_encoder.sv
// Button command encoder: synchronizes and debounces three raw buttons,
// queues presses one deep per button, and issues one-cycle command codes
// to a counter, waiting for its acknowledge between commands.
module button_encoder #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int ACK_TIMEOUT     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_min,
  input  logic       btn_sec0,
  input  logic       btn_rst,
  input  logic       encoder_reset,
  output logic [1:0] operation,
  output logic       busy,
  output logic       ack_error
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  // Button vector order: bit 0 = sec0, bit 1 = min, bit 2 = rst.
  localparam int B_SEC0 = 0;
  localparam int B_MIN  = 1;
  localparam int B_RST  = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_LOW
  } state_t;

  logic [2:0]      raw;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      level;
  logic [2:0]      rise;
  logic [2:0]      pending;
  logic [2:0]      pend_clr;
  logic [DB_W-1:0] db_cnt [3];

  state_t          state;
  state_t          state_next;
  logic [1:0]      cmd;
  logic [1:0]      cmd_next;
  logic [TO_W-1:0] ack_cnt;
  logic            timeout;

  assign raw = {btn_rst, btn_min, btn_sec0};

  // Two-flop synchronizer on every raw button.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge here, so it lives inside the
    // clocked branch rather than in the sensitivity list.
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      // NOTE: non-blocking assignments let sync2 take the old sync1, which is
      // what makes this a two-stage shift rather than a single wire.
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A debounced level rises when its last required differing sample arrives.
  always_comb begin
    // NOTE: every bit gets a value before the loop so no latch can be inferred.
    rise = '0;
    for (int i = 0; i < 3; i++) begin
      rise[i] = sync2[i] && !level[i] && (db_cnt[i] == DB_LAST);
    end
  end

  // Per-button debounce: count consecutive disagreeing samples, clear on agreement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= '0;
      // NOTE: the counters are a small array of flops, not a RAM, so clearing
      // them element by element in reset is cheap and intended.
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            level[i]  <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Pending press queue: a new rise wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~pend_clr) | rise;
  end

  // Command FSM next-state, selection and output decode.
  always_comb begin
    state_next = state;
    cmd_next   = cmd;
    pend_clr   = '0;
    timeout    = 1'b0;
    operation  = 2'b00;
    unique case (state)
      IDLE: begin
        if ((|pending) && !encoder_reset) begin
          state_next = ISSUE;
          if (pending[B_RST]) begin
            cmd_next = 2'b11;
            pend_clr = 3'b111;  // a clock reset makes queued edits moot
          end else if (pending[B_MIN]) begin
            cmd_next = 2'b10;
            pend_clr[B_MIN] = 1'b1;
          end else begin
            cmd_next = 2'b01;
            pend_clr[B_SEC0] = 1'b1;
          end
        end
      end
      ISSUE: begin
        operation  = cmd;
        state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (encoder_reset) begin
          state_next = WAIT_LOW;
        end else if (ack_cnt == TO_LAST) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_LOW: begin
        if (!encoder_reset) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, latched command, acknowledge timer and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd       <= 2'b00;
      ack_cnt   <= '0;
      ack_error <= 1'b0;
    end else begin
      state <= state_next;
      cmd   <= cmd_next;
      if (state == WAIT_ACK) ack_cnt <= ack_cnt + 1'b1;
      else                   ack_cnt <= '0;
      if (timeout) ack_error <= 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/button_encoder.md
BUTTON_ENCODER -- requirements
Module: button_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20, SHALL be the number of consecutive stable synchronized samples required to accept a new button level (20 ms at 1 kHz clk).
REQ-002 Parameter ACK_TIMEOUT, default 4, SHALL be the maximum cycles spent in WAIT_ACK before abandoning an issued command.
REQ-003 clk  input  1  SHALL be the single system clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on posedge clk.
REQ-005 btn_min  input  1  SHALL be the raw, asynchronous, active-high minute-add button.
REQ-006 btn_sec0  input  1  SHALL be the raw, asynchronous, active-high seconds-to-zero button.
REQ-007 btn_rst  input  1  SHALL be the raw, asynchronous, active-high clock-reset button.
REQ-008 encoder_reset  input  1  SHALL be the acknowledge from the counter, high for the cycle(s) after the counter consumes a command.
REQ-009 operation  output  2  SHALL be the command code: 00 no operation, 01 seconds to zero, 10 minute add, 11 clock reset.
REQ-010 busy  output  1  SHALL be high whenever the state machine is not in IDLE.
REQ-011 ack_error  output  1  SHALL be a sticky flag set on an acknowledge timeout.

Function
REQ-012 Each button SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Each synchronized button SHALL have its own debounce counter; the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive samples differing from the current debounced level; any agreeing sample SHALL clear that counter.
REQ-014 A 0->1 transition of a debounced level SHALL set that button's pending bit; 1->0 transitions SHALL have no effect.
REQ-015 Pending bits SHALL be set regardless of FSM state, so presses during busy are queued (one deep per button; repeated presses while pending SHALL merge).
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_ACK, WAIT_LOW.
REQ-017 IDLE: if any pending bit is set and encoder_reset is low, the FSM SHALL select by priority rst > min > sec0, clear the selected pending bit, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-018 Selecting rst SHALL also clear the min and sec0 pending bits (reset supersedes them).
REQ-019 ISSUE SHALL last exactly one cycle, driving operation with the selected code; the FSM SHALL then go unconditionally to WAIT_ACK.
REQ-020 In every state other than ISSUE, operation SHALL be 00, so each command is presented for exactly one clock and never double-applied.
REQ-021 WAIT_ACK: encoder_reset high SHALL move the FSM to WAIT_LOW; otherwise a cycle counter increments, and on reaching ACK_TIMEOUT the FSM SHALL set ack_error and return to IDLE.
REQ-022 WAIT_LOW SHALL hold until encoder_reset is low, then return to IDLE; there is no timeout in WAIT_LOW.
REQ-023 Minimum command spacing SHALL therefore be 4 cycles (ISSUE, WAIT_ACK, WAIT_LOW, IDLE).
REQ-024 A pending bit set in the same cycle as its selection in IDLE SHALL remain set, so the new press is queued.

Reset
REQ-025 While rst_n is low at a clock edge: operation=00, busy=0, ack_error=0, FSM=IDLE, all pending bits, synchronizers, debounced levels and counters SHALL be 0.
REQ-026 Reset asserted mid-command, including during ISSUE, SHALL abort the command with no further nonzero operation cycle; a button held through reset SHALL be accepted as a new press only after it debounces high again from 0.

Verification
REQ-027 btn_min held high 25 cycles, counter acking one cycle after ISSUE -> exactly one cycle of operation=10, about 22 cycles after press; busy high 3 cycles.
REQ-028 btn_min glitch high for 10 cycles only -> operation stays 00, no pending bit set.
REQ-029 btn_min and btn_sec0 debounce in the same cycle -> operation=10 for one cycle, then after the ack sequence operation=01 for one cycle.
REQ-030 btn_min pending, then btn_rst press -> operation=11 once; the min command is dropped.
REQ-031 encoder_reset tied low, one btn_sec0 press -> one cycle of operation=01, 4 cycles in WAIT_ACK, ack_error=1, FSM back to IDLE; ack_error stays 1 until rst_n=0.
REQ-032 rst_n pulsed low during WAIT_LOW with encoder_reset high -> next cycle all outputs 0; no command is issued until a fresh debounced press.
